// File: rtl/mem_lsu.sv
// ============================================================================
//  Module   : mem_lsu
//  Purpose  : Byte-serial load/store unit for the MEM stage. Memory
//             instructions stall the pipeline while the access is broken into
//             single-byte RAM cycles (little-endian). Non-memory instructions
//             pass straight through to writeback in the same cycle.
//  Option   : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
//             accesses skip the RAM phase and raise 'misalign' in DONE.
//  Ports    : clk, rst (async, active-high)
//             req_valid/req_mem/req_we/req_size/req_unsigned  - request
//             req_addr/req_wdata/alu_result, rd_i/wreg_i       - operands
//             ram_din (read byte, 1-cycle latency), ram_addr/ram_wr/ram_dout
//             stallreq_from_mem, wb_data/wb_rd/wb_we, [misalign]
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_mem,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] alu_result,
  input  logic [4:0]  rd_i,
  input  logic        wreg_i,
  input  logic [7:0]  ram_din,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic [7:0]  ram_dout,
  output logic        stallreq_from_mem,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        wb_we
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [2:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [4:0]  r_rd;
  logic        r_wreg;
  logic        r_we;
  logic [31:0] r_buf;
  logic        r_mis;

  logic        w_start;
  logic [2:0]  w_nbytes;
  logic        w_last;
  logic        w_req_mis;
  logic [1:0]  w_bidx;
  logic [31:0] w_ld_data;

  assign w_start = req_valid & req_mem;

  // Access length in bytes; size code 11 behaves as a word.
  always_comb begin
    case (r_size)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // Stores finish after N address cycles; loads need one extra cycle to
  // collect the byte returned for the final address.
  assign w_last = r_we ? (r_cnt == (w_nbytes - 3'd1)) : (r_cnt == w_nbytes);

  // Buffer slot for the byte arriving now (it belongs to address cnt-1).
  assign w_bidx = r_cnt[1:0] - 2'd1;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (req_size)
      2'b00:   w_req_mis = 1'b0;
      2'b01:   w_req_mis = req_addr[0];
      default: w_req_mis = (req_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign w_req_mis = 1'b0;
`endif

  // Sign/zero extension of the assembled load.
  always_comb begin
    case (r_size)
      2'b00:   w_ld_data = {{24{~r_uns & r_buf[7]}}, r_buf[7:0]};
      2'b01:   w_ld_data = {{16{~r_uns & r_buf[15]}}, r_buf[15:0]};
      default: w_ld_data = r_buf;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = w_req_mis ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: request capture, byte counter, load buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_rd    <= 5'd0;
      r_wreg  <= 1'b0;
      r_we    <= 1'b0;
      r_buf   <= 32'd0;
      r_mis   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt   <= 3'd0;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_rd    <= rd_i;
            r_wreg  <= wreg_i;
            r_we    <= req_we;
            r_buf   <= 32'd0;
            r_mis   <= w_req_mis;
          end
        end
        S_XFER: begin
          r_cnt <= r_cnt + 3'd1;
          if (!r_we && (r_cnt != 3'd0)) begin
            r_buf[{w_bidx, 3'b000} +: 8] <= ram_din;
          end
        end
        S_DONE: begin
          r_cnt <= 3'd0;
          r_mis <= 1'b0;
        end
        default: begin
          r_cnt <= 3'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic. Reset forces every output low without waiting for a clock,
  // so the IDLE pass-through is also masked while rst is high.
  // --------------------------------------------------------------------------
  always_comb begin
    ram_addr          = 32'd0;
    ram_wr            = 1'b0;
    ram_dout          = 8'd0;
    stallreq_from_mem = 1'b0;
    wb_data           = 32'd0;
    wb_rd             = 5'd0;
    wb_we             = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign          = 1'b0;
`endif
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            stallreq_from_mem = 1'b1;
          end else begin
            wb_data = alu_result;
            wb_rd   = rd_i;
            wb_we   = wreg_i & req_valid;
          end
        end
        S_XFER: begin
          stallreq_from_mem = 1'b1;
          if (r_we) begin
            ram_addr = r_addr + {29'd0, r_cnt};
            ram_wr   = 1'b1;
            ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
          end else if (r_cnt < w_nbytes) begin
            ram_addr = r_addr + {29'd0, r_cnt};
          end
        end
        S_DONE: begin
          wb_rd = r_rd;
          if (r_mis) begin
`ifdef LSU_MISALIGN_TRAP_EN
            misalign = 1'b1;
`endif
          end else begin
            wb_data = r_we ? 32'd0 : w_ld_data;
            wb_we   = r_wreg & ~r_we;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none

module tb_mem_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_mem;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] alu_result;
  logic [4:0]  rd_i;
  logic        wreg_i;
  logic [7:0]  ram_din;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic        stallreq_from_mem;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } wb_t;

  wb_t         exp_wb[$];
  logic [39:0] exp_wr[$];
  logic [39:0] wr_log[$];
  logic [7:0]  mem [0:1023];

  mem_lsu dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_mem           (req_mem),
    .req_we            (req_we),
    .req_size          (req_size),
    .req_unsigned      (req_unsigned),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .alu_result        (alu_result),
    .rd_i              (rd_i),
    .wreg_i            (wreg_i),
    .ram_din           (ram_din),
    .ram_addr          (ram_addr),
    .ram_wr            (ram_wr),
    .ram_dout          (ram_dout),
    .stallreq_from_mem (stallreq_from_mem),
    .wb_data           (wb_data),
    .wb_rd             (wb_rd),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign          (misalign),
`endif
    .wb_we             (wb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide RAM, registered read data (valid one cycle after address).
  always @(posedge clk) begin
    ram_din <= mem[ram_addr[9:0]];
    if (ram_wr) begin
      mem[ram_addr[9:0]] = ram_dout;
      wr_log.push_back({ram_addr, ram_dout});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Quiet-bus monitor: RAM lines idle except during store/load transfers.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ram_wr !== 1'b1) chk("dout_idle", {24'd0, ram_dout}, 32'd0);
      if (stallreq_from_mem === 1'b0) begin
        chk("addr_idle", ram_addr, 32'd0);
        chk("wr_idle", {31'd0, ram_wr}, 32'd0);
      end
    end
  end

  // Drive one memory instruction (called #1 after a rising edge in IDLE),
  // count stall cycles, then check the DONE writeback against the scoreboard.
  task automatic mem_op(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic wreg, input int exp_stall,
                        input logic [31:0] exp_data);
    int  stalls;
    int  n;
    wb_t e;
    wb_t w;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    e.data = we ? 32'd0 : exp_data;
    e.rd   = rd;
    e.we   = wreg & ~we;
    exp_wb.push_back(e);
    exp_wr.delete();
    wr_log.delete();
    if (we && exp_stall > 1)
      for (int i = 0; i < n; i++) exp_wr.push_back({addr + i, wdata[8*i +: 8]});
    req_valid = 1'b1; req_mem = 1'b1; req_we = we; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata; rd_i = rd; wreg_i = wreg;
    alu_result = 32'hDEAD_0000;
    stalls = 0;
    #1;
    while (stallreq_from_mem === 1'b1 && stalls < 20) begin
      chk({tag, "_stall_we"}, {31'd0, wb_we}, 32'd0);
      stalls++;
      @(posedge clk); #1;
    end
    chk({tag, "_stalls"}, stalls, exp_stall);
    w = exp_wb.pop_front();
    chk({tag, "_wb_data"}, wb_data, w.data);
    chk({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, w.rd});
    chk({tag, "_wb_we"}, {31'd0, wb_we}, {31'd0, w.we});
    chk({tag, "_nwrites"}, wr_log.size(), exp_wr.size());
    while (exp_wr.size() > 0 && wr_log.size() > 0)
      chk({tag, "_write"}, wr_log.pop_front(), exp_wr.pop_front());
    req_valid = 1'b0; req_mem = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h78; mem[10'h101] = 8'h56;
    mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
    mem[10'h104] = 8'hAB; mem[10'h105] = 8'hCD;
    mem[10'h020] = 8'h80;

    rst = 1'b1; req_valid = 1'b1; req_mem = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    alu_result = 32'h1234; rd_i = 5'd7; wreg_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_stall", {31'd0, stallreq_from_mem}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    rst = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;

    // Non-memory pass-through
    req_valid = 1'b1; req_mem = 1'b0; alu_result = 32'h5; rd_i = 5'd3; wreg_i = 1'b1;
    #1;
    chk("pass_data", wb_data, 32'h5);
    chk("pass_rd", {27'd0, wb_rd}, 32'd3);
    chk("pass_we", {31'd0, wb_we}, 32'd1);
    chk("pass_stall", {31'd0, stallreq_from_mem}, 32'd0);
    req_valid = 1'b0;
    #1;
    chk("novalid_we", {31'd0, wb_we}, 32'd0);
    @(posedge clk); #1;

    mem_op("ldw",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0,    5'd4, 1'b1, 6, 32'h1234_5678);
    mem_op("ldbs", 1'b0, 2'b00, 1'b0, 32'h20,  32'h0,    5'd5, 1'b1, 3, 32'hFFFF_FF80);
    mem_op("ldbu", 1'b0, 2'b00, 1'b1, 32'h20,  32'h0,    5'd6, 1'b1, 3, 32'h0000_0080);
    mem_op("sth",  1'b1, 2'b01, 1'b0, 32'h40,  32'hBEEF, 5'd7, 1'b1, 3, 32'h0);
    mem_op("ldhs", 1'b0, 2'b01, 1'b0, 32'h40,  32'h0,    5'd8, 1'b1, 4, 32'hFFFF_BEEF);
    mem_op("ldhu", 1'b0, 2'b01, 1'b1, 32'h40,  32'h0,    5'd9, 1'b1, 4, 32'h0000_BEEF);
    mem_op("stb",  1'b1, 2'b00, 1'b0, 32'h30,  32'h5A,   5'd1, 1'b1, 2, 32'h0);
    mem_op("ldb",  1'b0, 2'b00, 1'b0, 32'h30,  32'h0,    5'd2, 1'b0, 3, 32'h0000_005A);
    mem_op("stw",  1'b1, 2'b11, 1'b0, 32'h50,  32'hCAFE_F00D, 5'd10, 1'b1, 5, 32'h0);
    mem_op("ldw2", 1'b0, 2'b11, 1'b0, 32'h50,  32'h0,    5'd11, 1'b1, 6, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
    req_valid = 1'b1; req_mem = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_addr = 32'h102; rd_i = 5'd12; wreg_i = 1'b1; wr_log.delete();
    #1;
    chk("mis_stall1", {31'd0, stallreq_from_mem}, 32'd1);
    chk("mis_addr1", ram_addr, 32'd0);
    @(posedge clk); #1;
    chk("mis_stall_done", {31'd0, stallreq_from_mem}, 32'd0);
    chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_we", {31'd0, wb_we}, 32'd0);
    chk("mis_addr", ram_addr, 32'd0);
    chk("mis_nwrites", wr_log.size(), 0);
    req_valid = 1'b0; req_mem = 1'b0;
    @(posedge clk); #1;
    chk("mis_clear", {31'd0, misalign}, 32'd0);
`else
    mem_op("ldmis", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 5'd12, 1'b1, 6, 32'hCDAB_1234);
`endif

    // Reset during the third XFER cycle of a word load
    req_valid = 1'b1; req_mem = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h100; rd_i = 5'd13; wreg_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ab_pre_addr", ram_addr, 32'h102);
    req_valid = 1'b0; req_mem = 1'b0;
    rst = 1'b1;
    #1;
    chk("ab_stall", {31'd0, stallreq_from_mem}, 32'd0);
    chk("ab_addr", ram_addr, 32'd0);
    chk("ab_wb_data", wb_data, 32'd0);
    chk("ab_wb_we", {31'd0, wb_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("ab_post_we", {31'd0, wb_we}, 32'd0);
      chk("ab_post_stall", {31'd0, stallreq_from_mem}, 32'd0);
      @(posedge clk); #1;
    end

    mem_op("ldw_after", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd14, 1'b1, 6, 32'h1234_5678);
    chk("sb_empty", exp_wb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have these ports: clk  in  1  system clock, all state on rising edge.
REQ-002 rst  in  1  reset; asynchronous, active-high.
REQ-003 req_valid  in  1  MEM-stage instruction present; req_mem  in  1  instruction is load/store; req_we  in  1  1=store, 0=load.
REQ-004 req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word. req_unsigned  in  1  zero-extend load.
REQ-005 req_addr  in  32  byte address; req_wdata  in  32  store data; alu_result  in  32  non-memory result.
REQ-006 rd_i  in  5  destination register; wreg_i  in  1  destination write enable.
REQ-007 ram_din  in  8  RAM read byte, valid one cycle after address; ram_addr  out  32; ram_wr  out  1; ram_dout  out  8.
REQ-008 stallreq_from_mem  out  1  stall request to the stall controller; wb_data  out  32; wb_rd  out  5; wb_we  out  1.
REQ-009 misalign  out  1  misaligned access flag; present only with LSU_MISALIGN_TRAP_EN.

Function
REQ-010 FSM states SHALL be IDLE, XFER, DONE; N = access size in bytes (1, 2, 4).
REQ-011 IDLE, req_valid=0 or req_mem=0: combinational pass-through, wb_data=alu_result, wb_rd=rd_i, wb_we=wreg_i&req_valid, stallreq_from_mem=0.
REQ-012 IDLE, req_valid=1 and req_mem=1: stallreq_from_mem=1 that same cycle; latch addr/wdata/size/unsigned/rd/wreg; cnt<=0; next XFER.
REQ-013 XFER: stallreq_from_mem=1; ram_addr=addr_q+cnt (32-bit wrap); cnt increments each cycle.
REQ-014 Store in XFER: ram_wr=1, ram_dout=wdata_q byte cnt (little-endian); leave XFER after N cycles (cnt=N-1).
REQ-015 Load in XFER: ram_wr=0; ram_din captured into byte cnt-1 of buffer when cnt>=1; issue addresses for cnt<N; leave after N+1 cycles.
REQ-016 DONE: stallreq_from_mem=0; wb_data=assembled load (sign- or zero-extended per size/unsigned) or 0 for store; wb_rd=rd_q; wb_we=wreg_q&~store; next IDLE.
REQ-017 Total stall cycles SHALL be N+2 for loads, N+1 for stores; word load 6, byte store 2.
REQ-018 Outside store XFER cycles ram_wr SHALL be 0 and ram_dout 0; ram_addr 0 in IDLE/DONE.
REQ-019 req_* inputs SHALL be ignored in XFER and DONE (pipeline frozen); DONE never restarts an access.
REQ-020 Back-to-back memory instructions: new access accepted in the IDLE cycle following DONE.

Reset
REQ-021 rst=1 SHALL immediately force IDLE, cnt=0, buffers 0, ram_wr=0, ram_addr=0, ram_dout=0, wb_* =0, stallreq_from_mem=0, misalign=0.
REQ-022 rst asserted mid-XFER SHALL abort the access; no partial writeback; a store byte already written remains in RAM.

Configuration
REQ-023 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL skip XFER, go IDLE->DONE (1 stall cycle), misalign=1 in DONE, wb_we=0, no RAM traffic.
REQ-024 Macro undefined: misalign port absent; misaligned accesses proceed byte-serially per REQ-013..016.

Verification
REQ-025 Word load addr 0x100, RAM 0x100..0x103 = 78,56,34,12 -> stall 6 cycles, DONE wb_data=0x12345678, wb_we=1.
REQ-026 Byte load signed addr 0x20 holding 0x80 -> wb_data=0xFFFFFF80; with req_unsigned=1 -> 0x00000080.
REQ-027 Half store 0xBEEF to 0x40 -> ram_wr=1 two cycles, (0x40,EF),(0x41,BE), stall 3 cycles, wb_we=0.
REQ-028 Non-memory op alu_result=0x5, rd_i=3 -> same-cycle wb_data=0x5, wb_rd=3, no stall.
REQ-029 rst pulse during 3rd XFER cycle of word load -> outputs zero at once, IDLE, no wb_we pulse after release.
REQ-030 With LSU_MISALIGN_TRAP_EN, word load addr 0x102 -> 1 stall cycle, misalign=1, no ram_addr change, wb_we=0.
